ritc_phase_scan_sequencer: RTL

//  Sequences the RITC phase scan: steps the CLK_PS MMCM phase one increment at a time, waits for the

---
 rtl/ritc_phase_scan_sequencer.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ritc_phase_scan_sequencer.sv
// ritc_phase_scan_sequencer
// Steps the CLK_PS MMCM phase one increment at a time. After each step it waits for PSDONE,
// lets the sample registers settle, then counts ones on one selected SCAN_IN bit over
// 2**SAMPLE_BITS cycles. One (step, count) result is streamed out per step with a valid/ready
// handshake. An unaccepted result stalls the scan.
// Optional build macro: RITC_PHASE_SCAN_RETURN_EN. When it is defined, every phase step is
// undone after the last result is accepted, so the MMCM ends at its pre-scan phase.
module ritc_phase_scan_sequencer #(
    parameter int NUM_INPUTS     = 40,
    parameter int SEL_BITS       = 6,
    parameter int STEP_BITS      = 10,
    parameter int SAMPLE_BITS    = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int PSDONE_TIMEOUT = 1023
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [SEL_BITS-1:0]   scan_sel,
    input  logic [STEP_BITS-1:0]  scan_steps,
    input  logic                  scan_dec,
    input  logic [NUM_INPUTS-1:0] SCAN_IN,
    output logic                  PSEN,
    output logic                  PSINCDEC,
    input  logic                  PSDONE,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [STEP_BITS-1:0]  res_step,
    output logic [SAMPLE_BITS:0]  res_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int SEL_SPAN = 1 << SEL_BITS;
    localparam int CNT_W    = SAMPLE_BITS + 1;
    localparam int TMO_W    = $clog2(PSDONE_TIMEOUT + 1);
    localparam int SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam int CYC_A    = (TMO_W > CNT_W) ? TMO_W : CNT_W;
    localparam int CYC_W    = (CYC_A > SET_W) ? CYC_A : SET_W;

    localparam logic [CYC_W-1:0]     TMO_LAST = CYC_W'(PSDONE_TIMEOUT - 1);
    localparam logic [CYC_W-1:0]     SET_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0]     SMP_LAST = CYC_W'((1 << SAMPLE_BITS) - 1);
    localparam logic [CYC_W-1:0]     CYC_ONE  = CYC_W'(1);
    localparam logic [STEP_BITS-1:0] STEP_ONE = STEP_BITS'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT_DONE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT,
        ST_FINISH
`ifdef RITC_PHASE_SCAN_RETURN_EN
        ,
        ST_RETURN,
        ST_RET_WAIT
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [CYC_W-1:0]       cyc_q, cyc_d;        // shared timeout / settle / sample counter
    logic [STEP_BITS-1:0]   step_q, step_d;      // result index; reused as undo counter
    logic [STEP_BITS-1:0]   steps_q, steps_d;
    logic [SEL_BITS-1:0]    sel_q, sel_d;
    logic                   dec_q, dec_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   error_q, error_d;
    logic                   psen_q, psen_d;
    logic                   psincdec_q, psincdec_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [SEL_SPAN-1:0]    scan_pad_s;
    logic                   bit_s;
    logic                   last_step_s;

    // Zero-extend SCAN_IN so any selector beyond NUM_INPUTS reads as 0.
    assign scan_pad_s  = SEL_SPAN'(SCAN_IN);
    assign bit_s       = scan_pad_s[sel_q];
    // steps_q == 0 encodes the full 2**STEP_BITS range: the last index then wraps to all-ones.
    assign last_step_s = ((step_q + STEP_ONE) == steps_q);

    assign PSEN      = psen_q;
    assign PSINCDEC  = psincdec_q;
    assign res_valid = valid_q;
    assign res_step  = step_q;
    assign res_count = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

    // Next-state and next-output logic; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + CYC_ONE;
        step_d  = step_q;
        steps_d = steps_q;
        sel_d   = sel_q;
        dec_d   = dec_q;
        count_d = count_q;
        error_d = error_q;

        case (state_q)
            ST_IDLE: begin
                cyc_d = '0;
                if (start) begin
                    state_d = ST_SHIFT;
                    sel_d   = scan_sel;
                    steps_d = scan_steps;
                    dec_d   = scan_dec;
                    error_d = 1'b0;
                    step_d  = '0;
                    count_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                cyc_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (PSDONE) begin
                    cyc_d   = '0;
                    state_d = ST_SETTLE;
                end else if (cyc_q == TMO_LAST) begin
                    cyc_d   = '0;
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == SET_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                count_d = count_q + CNT_W'(bit_s);
                if (cyc_q == SMP_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_REPORT: begin
                cyc_d = '0;
                if (!res_ready) begin
                    state_d = ST_REPORT;
                end else if (last_step_s) begin
`ifdef RITC_PHASE_SCAN_RETURN_EN
                    step_d  = '0;
                    state_d = ST_RETURN;
`else
                    state_d = ST_FINISH;
`endif
                end else begin
                    step_d  = step_q + STEP_ONE;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_FINISH: begin
                cyc_d   = '0;
                state_d = ST_IDLE;
            end
`ifdef RITC_PHASE_SCAN_RETURN_EN
            ST_RETURN: begin
                cyc_d   = '0;
                state_d = ST_RET_WAIT;
            end
            ST_RET_WAIT: begin
                if (PSDONE) begin
                    cyc_d = '0;
                    if (last_step_s) begin
                        state_d = ST_FINISH;
                    end else begin
                        step_d  = step_q + STEP_ONE;
                        state_d = ST_RETURN;
                    end
                end else if (cyc_q == TMO_LAST) begin
                    cyc_d   = '0;
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RET_WAIT;
                end
            end
`endif
            default: begin
                cyc_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

`ifdef RITC_PHASE_SCAN_RETURN_EN
        psen_d = (state_d == ST_SHIFT) || (state_d == ST_RETURN);
`else
        psen_d = (state_d == ST_SHIFT);
`endif
        if (state_d == ST_IDLE) begin
            psincdec_d = 1'b0;
        end else if (state_d == ST_SHIFT) begin
            psincdec_d = dec_d;
`ifdef RITC_PHASE_SCAN_RETURN_EN
        end else if (state_d == ST_RETURN) begin
            psincdec_d = ~dec_q;
`endif
        end else begin
            psincdec_d = psincdec_q;
        end
        valid_d = (state_d == ST_REPORT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
    end

    // State, datapath and output registers; reset aborts any scan immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            step_q     <= '0;
            steps_q    <= '0;
            sel_q      <= '0;
            dec_q      <= 1'b0;
            count_q    <= '0;
            error_q    <= 1'b0;
            psen_q     <= 1'b0;
            psincdec_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            step_q     <= step_d;
            steps_q    <= steps_d;
            sel_q      <= sel_d;
            dec_q      <= dec_d;
            count_q    <= count_d;
            error_q    <= error_d;
            psen_q     <= psen_d;
            psincdec_q <= psincdec_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule
